// File: rtl/new_feat_wr_arbiter_if.sv
// Lane-to-arbiter request bundle plus the new-feature BRAM write port.
// master = aggregator lanes / BRAM side, slave = the arbiter.
interface new_feat_wr_arbiter_if #(
  parameter int NUM_REQ           = 4,
  parameter int NUM_FEATURE_OUT   = 16,
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NUM_SUBGRAPHS     = 2708
);
  localparam int NODE_IDX_W = $clog2(NUM_SUBGRAPHS);
  localparam int ADDR_W     = $clog2(NUM_SUBGRAPHS*NUM_FEATURE_OUT);

  logic [NUM_REQ-1:0]                                             req_vld;
  logic [NUM_REQ-1:0][NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] req_feat;
  logic [NUM_REQ-1:0][NODE_IDX_W-1:0]                             req_node_idx;
  logic [NUM_REQ-1:0]                                             req_rdy;
  logic [ADDR_W-1:0]                                              feat_bram_addra;
  logic [NEW_FEATURE_WIDTH-1:0]                                   feat_bram_din;
  logic                                                           feat_bram_ena;

  modport master (
    output req_vld, req_feat, req_node_idx,
    input  req_rdy, feat_bram_addra, feat_bram_din, feat_bram_ena
  );

  modport slave (
    input  req_vld, req_feat, req_node_idx,
    output req_rdy, feat_bram_addra, feat_bram_din, feat_bram_ena
  );
endinterface

// File: rtl/new_feat_wr_arbiter.sv
// Round-robin arbiter serializing lane feature vectors into the new-feature BRAM.
// Define FEAT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module new_feat_wr_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int NUM_FEATURE_OUT   = 16,
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NUM_SUBGRAPHS     = 2708,
  localparam int NODE_IDX_W = $clog2(NUM_SUBGRAPHS),
  localparam int ADDR_W     = $clog2(NUM_SUBGRAPHS*NUM_FEATURE_OUT),
  localparam int K_W        = $clog2(NUM_FEATURE_OUT),
  localparam int CNT_W      = $clog2(NUM_SUBGRAPHS+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  new_feat_wr_arbiter_if.slave     bus,
  output logic                     busy,
  output logic [CNT_W-1:0]         done_cnt,
  output logic                     err_oob,
  output logic                     gat_ready
);
  localparam int                RR_W     = $clog2(NUM_REQ);
  localparam logic [K_W-1:0]    K_LAST   = K_W'(NUM_FEATURE_OUT-1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_SUBGRAPHS);
  localparam logic [ADDR_W-1:0] VEC_LEN  = ADDR_W'(NUM_FEATURE_OUT);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                                         state, state_nxt;
  logic [RR_W-1:0]                                rr_ptr;
  logic                                           grant_vld;
  logic [RR_W-1:0]                                grant_idx;
  logic [K_W-1:0]                                 k;
  logic [NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] vec_buf;
  logic [NODE_IDX_W-1:0]                          node_sel;
  logic                                           oob_sel;
  logic [CNT_W-1:0]                               done_inc;

  assign node_sel = bus.req_node_idx[grant_idx];
  assign oob_sel  = (int'(node_sel) >= NUM_SUBGRAPHS);
  assign done_inc = (done_cnt == CNT_FULL) ? done_cnt : done_cnt + 1'b1;

  // Winner search: descending loop so the lowest offset from the start lane wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = NUM_REQ-1; off >= 0; off--) begin
`ifdef FEAT_ARB_FIXED_PRIO_EN
      if (bus.req_vld[off]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(off);
      end
`else
      if (bus.req_vld[(int'(rr_ptr) + off) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'((int'(rr_ptr) + off) % NUM_REQ);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld)   state_nxt = WRITE;
      WRITE:   if (k == K_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_rdy = '0;
    busy        = (state == WRITE);
    if (rst_n && state == IDLE && grant_vld) bus.req_rdy[grant_idx] = 1'b1;
  end

  // Grant edge preloads word 0 so the BRAM port is register-driven from T+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k                   <= '0;
      bus.feat_bram_addra <= '0;
      bus.feat_bram_din   <= '0;
      bus.feat_bram_ena   <= 1'b0;
      done_cnt            <= '0;
      err_oob             <= 1'b0;
      gat_ready           <= 1'b0;
      rr_ptr              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            k                   <= '0;
            bus.feat_bram_addra <= ADDR_W'(node_sel) * VEC_LEN;
            bus.feat_bram_din   <= bus.req_feat[grant_idx][0];
            bus.feat_bram_ena   <= !oob_sel;
            err_oob             <= err_oob | oob_sel;
`ifdef FEAT_ARB_FIXED_PRIO_EN
            rr_ptr              <= '0;
`else
            rr_ptr              <= (grant_idx == RR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
`endif
          end
        end
        WRITE: begin
          if (k == K_LAST) begin
            bus.feat_bram_ena <= 1'b0;
            done_cnt          <= done_inc;
            gat_ready         <= gat_ready | (done_inc == CNT_FULL);
          end else begin
            k                   <= k + 1'b1;
            bus.feat_bram_addra <= bus.feat_bram_addra + 1'b1;
            bus.feat_bram_din   <= vec_buf[k + 1'b1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && grant_vld) vec_buf <= bus.req_feat[grant_idx];
  end
endmodule

// File: tb/tb_new_feat_wr_arbiter.sv
// Randomized scoreboard bench for new_feat_wr_arbiter with a small subgraph count
// so completion, saturation and out-of-range indices are all reachable.
module tb_new_feat_wr_arbiter;
  localparam int NR   = 4;
  localparam int NFO  = 16;
  localparam int W    = 32;
  localparam int NS   = 5;
  localparam int NIW  = $clog2(NS);
  localparam int AW   = $clog2(NS*NFO);
  localparam int CW   = $clog2(NS+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy;
  logic [CW-1:0] done_cnt;
  logic          err_oob;
  logic          gat_ready;

  always #5 clk = ~clk;

  new_feat_wr_arbiter_if #(.NUM_REQ(NR), .NUM_FEATURE_OUT(NFO),
                           .NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(NS)) bus ();

  new_feat_wr_arbiter #(.NUM_REQ(NR), .NUM_FEATURE_OUT(NFO),
                        .NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .done_cnt(done_cnt), .err_oob(err_oob), .gat_ready(gat_ready)
  );

  typedef struct {
    int           addr;
    logic [W-1:0] data;
    bit           ena;
    int           k;
    bit           oob;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  bit                     have [NR];
  int                     node [NR];
  logic [NFO-1:0][W-1:0]  feat [NR];

  int cyc = 0, free_at = 0, rr = 0, last_grant = -100;
  int sb_done = 0;
  bit sb_err = 1'b0, sb_gat = 1'b0;
  bit in_reset = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < NR; i++) begin
      bus.req_vld[i]      = have[i];
      bus.req_feat[i]     = feat[i];
      bus.req_node_idx[i] = NIW'(node[i]);
    end
  endtask

  task automatic new_vec(input int i, input int nd);
    have[i] = 1'b1;
    node[i] = nd;
    for (int w = 0; w < NFO; w++) feat[i][w] = $urandom;
  endtask

  // One arbitration cycle: update lanes, drive, then predict and check the grant.
  task automatic step(input int p_new, input int p_drop);
    logic [NR-1:0] exp_rdy;
    int g, start;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (!have[i] && $urandom_range(99) < p_new) new_vec(i, $urandom_range(0, 7));
      else if (have[i] && $urandom_range(99) < p_drop) have[i] = 1'b0;
    end
    drive_lanes();
    #2;
    exp_rdy = '0;
    g = -1;
`ifdef FEAT_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = rr;
`endif
    if (cyc >= free_at) begin
      for (int off = 0; off < NR; off++) begin
        if (g < 0 && have[(start + off) % NR]) g = (start + off) % NR;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
    if (g >= 0) begin
      for (int w = 0; w < NFO; w++) begin
        wr_t it;
        it.addr = node[g] * NFO + w;
        it.data = feat[g][w];
        it.oob  = (node[g] >= NS);
        it.ena  = !it.oob;
        it.k    = w;
        exp_q.push_back(it);
      end
      free_at    = cyc + NFO + 1;
      rr         = (g + 1) % NR;
      have[g]    = 1'b0;
      last_grant = cyc;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ena"},   64'(bus.feat_bram_ena),   64'(0));
    check({tag, "_addr"},  64'(bus.feat_bram_addra), 64'(0));
    check({tag, "_din"},   64'(bus.feat_bram_din),   64'(0));
    check({tag, "_busy"},  64'(busy),                64'(0));
    check({tag, "_done"},  64'(done_cnt),            64'(0));
    check({tag, "_err"},   64'(err_oob),             64'(0));
    check({tag, "_gat"},   64'(gat_ready),           64'(0));
    check({tag, "_rdy"},   64'(bus.req_rdy),         64'(0));
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NR; i++) begin
      have[i] = 1'b0;
      node[i] = 0;
      feat[i] = '0;
    end
    drive_lanes();
  endtask

  // Monitor: pops one expected write per busy cycle, tracks sticky status.
  initial begin
    wr_t it;
    bit last;
    forever begin
      @(posedge clk);
      #1;
      if (in_reset) continue;
      last = 1'b0;
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check("busy_on", 64'(busy), 64'(1));
        check("ena", 64'(bus.feat_bram_ena), 64'(it.ena));
        if (it.ena) begin
          check("addr", 64'(bus.feat_bram_addra), 64'(it.addr));
          check("din",  64'(bus.feat_bram_din),   64'(it.data));
        end
        if (it.k == 0 && it.oob) sb_err = 1'b1;
        last = (it.k == NFO - 1);
      end else begin
        check("busy_off", 64'(busy), 64'(0));
        check("ena_off",  64'(bus.feat_bram_ena), 64'(0));
      end
      check("err_oob",   64'(err_oob),   64'(sb_err));
      check("done_cnt",  64'(done_cnt),  64'(sb_done));
      check("gat_ready", 64'(gat_ready), 64'(sb_gat));
      if (last) begin
        if (sb_done < NS) sb_done++;
        if (sb_done == NS) sb_gat = 1'b1;
      end
    end
  end

  initial begin
    bit hit;
    int t0;
    rst_n = 1'b0;
    clear_lanes();
    bus.req_vld = '1;
    #3;
    check_outputs_zero("reset");
    bus.req_vld = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;

    // Single lane 1, node 3, words 0x100+k -> addresses 48..63.
    have[1] = 1'b1;
    node[1] = 3;
    for (int w = 0; w < NFO; w++) feat[1][w] = W'(32'h100 + w);
    repeat (20) step(0, 0);

    // Out-of-range node index: accepted, no writes, sticky error.
    new_vec(2, 6);
    repeat (20) step(0, 0);
    check("err_oob_sticky", 64'(err_oob), 64'(1));

    // All lanes continuously valid: round-robin rotation, completion, saturation.
    for (int i = 0; i < NR; i++) new_vec(i, i);
    repeat (5 * (NFO + 1) + 2) step(100, 0);
    check("gat_final", 64'(gat_ready), 64'(1));
    check("done_sat",  64'(done_cnt),  64'(NS));

    // Random traffic with withdrawals.
    repeat (300) step(30, 10);

    // Reset while write k=5 of a vector is on the port.
    hit = 1'b0;
    t0  = cyc;
    for (int n = 0; n < 60 && !hit; n++) begin
      step(100, 0);
      if (last_grant > t0 && cyc == last_grant + 6) hit = 1'b1;
    end
    check("reset_trigger", 64'(hit), 64'(1));
    in_reset = 1'b1;
    rst_n    = 1'b0;
    clear_lanes();
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    rr      = 0;
    free_at = 0;
    sb_done = 0;
    sb_err  = 1'b0;
    sb_gat  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    repeat (5) step(0, 0);
    repeat (300) step(40, 5);
    repeat (5 * (NFO + 1)) step(0, 0);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
